// File: rtl/otter_mem_pkg.sv
// Shared types and helpers for the OTTER memory/IO bus arbiter.
// The transaction record is sized to the widest bus the arbiter supports;
// the arbiter's own ADDR_W/DATA_W must not exceed TXN_ADDR_W/TXN_DATA_W.
package otter_mem_pkg;

    localparam int TXN_ADDR_W = 32;
    localparam int TXN_DATA_W = 32;

    // Arbiter sequencing state: free, or owning the bus on behalf of one port
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_t;

    // Access size carried through to the memory/IO side untouched
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    // Everything the memory side needs for one transaction, latched at grant
    typedef struct packed {
        logic                  we;
        logic [TXN_ADDR_W-1:0] addr;
        logic [TXN_DATA_W-1:0] wdata;
        mem_size_t             size;
        logic                  sign;
    } mem_txn_t;

    // Saturating increment used by the instruction-fetch starvation counter
    function automatic logic [3:0] starve_inc(input logic [3:0] cur,
                                              input logic [3:0] limit);
        return (cur >= limit) ? limit : cur + 4'd1;
    endfunction

endpackage

// File: rtl/otter_mem_arbiter.sv
// Shares the single-ported OTTER memory/IO bus between the fetch port (IF)
// and the MEM-stage data port (D). Data accesses win by default so the
// older instruction in MEM drains first; a small counter forces a fetch
// through after MAX_IF_WAIT data grants so IF cannot starve behind a run
// of loads/stores. Each transaction is held on M_* until M_ACK and the
// result is returned one cycle later as a single VALID pulse.
import otter_mem_pkg::*;

module otter_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_IF_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,

    input  logic              IF_REQ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    output logic              IF_GNT,
    output logic              IF_VALID,
    output logic [DATA_W-1:0] IF_RDATA,

    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    input  logic [1:0]        D_SIZE,
    input  logic              D_SIGN,
    output logic              D_GNT,
    output logic              D_VALID,
    output logic [DATA_W-1:0] D_RDATA,

    output logic              M_REQ,
    output logic              M_WE,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_WDATA,
    output logic [1:0]        M_SIZE,
    output logic              M_SIGN,
    input  logic              M_ACK,
    input  logic [DATA_W-1:0] M_RDATA,

    output logic              STALL_IF,
    output logic              STALL_MEM
);

    localparam logic [3:0] STARVE_MAX = 4'(MAX_IF_WAIT);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [3:0]        starve_q;
    mem_txn_t          txn_q;
    mem_txn_t          if_txn;
    mem_txn_t          d_txn;
    logic              if_valid_q;
    logic              d_valid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              idle;
    logic              starve_full;
    logic              d_win;
    logic              if_win;
    logic              if_done;
    logic              d_done;

    assign idle        = (state_q == IDLE);
    assign starve_full = (starve_q == STARVE_MAX);
    assign if_done     = (state_q == BUSY_IF) && M_ACK;
    assign d_done      = (state_q == BUSY_D) && M_ACK;

    // Same-cycle grant decision while the bus is free: data first, unless
    // fetch has been passed over MAX_IF_WAIT times and is still asking
    always_comb begin
        d_win  = 1'b0;
        if_win = 1'b0;
        if (RESET_N && idle) begin
            d_win  = D_REQ && !(IF_REQ && starve_full);
            if_win = IF_REQ && !d_win;
        end
    end

    // Transaction records for each port as they would be latched on grant;
    // fetches are always full-word reads
    always_comb begin
        if_txn       = '0;
        if_txn.we    = 1'b0;
        if_txn.addr  = TXN_ADDR_W'(IF_ADDR);
        if_txn.wdata = '0;
        if_txn.size  = WORD;
        if_txn.sign  = 1'b0;

        d_txn        = '0;
        d_txn.we     = D_WE;
        d_txn.addr   = TXN_ADDR_W'(D_ADDR);
        d_txn.wdata  = TXN_DATA_W'(D_WDATA);
        d_txn.size   = mem_size_t'(D_SIZE);
        d_txn.sign   = D_SIGN;
    end

    // Next-state logic: claim the bus for the winner, release it on M_ACK
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_win) begin
                    state_d = BUSY_D;
                end else if (if_win) begin
                    state_d = BUSY_IF;
                end
            end
            BUSY_IF,
            BUSY_D: begin
                if (M_ACK) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; an asynchronous reset abandons any open transaction
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Starvation counter: counts data grants that IF had to sit through
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            starve_q <= 4'd0;
        end else if (if_win) begin
            starve_q <= 4'd0;
        end else if (d_win && IF_REQ) begin
            starve_q <= starve_inc(starve_q, STARVE_MAX);
        end
    end

    // Transaction register: captured on grant and held steady while busy
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            txn_q <= '0;
        end else if (d_win) begin
            txn_q <= d_txn;
        end else if (if_win) begin
            txn_q <= if_txn;
        end
    end

    // Completion pulses, one cycle after the memory acknowledges
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
        end else begin
            if_valid_q <= if_done;
            d_valid_q  <= d_done;
        end
    end

    // Read-data capture; each port keeps its last result until its next completion
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_done) begin
                if_rdata_q <= M_RDATA;
            end
            if (d_done) begin
                d_rdata_q <= txn_q.we ? '0 : M_RDATA;
            end
        end
    end

    assign IF_GNT    = if_win;
    assign D_GNT     = d_win;
    assign IF_VALID  = if_valid_q;
    assign D_VALID   = d_valid_q;
    assign IF_RDATA  = if_rdata_q;
    assign D_RDATA   = d_rdata_q;

    assign M_REQ     = !idle;
    assign M_WE      = txn_q.we;
    assign M_ADDR    = txn_q.addr[ADDR_W-1:0];
    assign M_WDATA   = txn_q.wdata[DATA_W-1:0];
    assign M_SIZE    = txn_q.size;
    assign M_SIGN    = txn_q.sign;

    assign STALL_IF  = RESET_N && IF_REQ && !if_valid_q;
    assign STALL_MEM = RESET_N && D_REQ && !d_valid_q;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Self-checking bench for otter_mem_arbiter: a transaction-level model of
// the arbitration rules predicts every grant, the bus ownership, and the
// data each port should get back; a responding memory model sits on the
// M_* side with random or fixed latency and occasional stray acks.
module tb_otter_mem_arbiter;

    localparam int MAX_WAIT = 4;

    typedef struct {
        bit          isD;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          sign;
    } txn_t;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        IF_REQ, IF_GNT, IF_VALID;
    logic [31:0] IF_ADDR, IF_RDATA;
    logic        D_REQ, D_WE, D_SIGN, D_GNT, D_VALID;
    logic [31:0] D_ADDR, D_WDATA, D_RDATA;
    logic [1:0]  D_SIZE;
    logic        M_REQ, M_WE, M_SIGN, M_ACK;
    logic [31:0] M_ADDR, M_WDATA, M_RDATA;
    logic [1:0]  M_SIZE;
    logic        STALL_IF, STALL_MEM;

    // stimulus sources: random drivers or directed sequences
    bit          runDrivers = 0;
    logic        rIfReq = 0, rDReq = 0, rDWe = 0, rDSign = 0;
    logic [31:0] rIfAddr = 0, rDAddr = 0, rDWdata = 0;
    logic [1:0]  rDSize = 0;
    logic        dirIfReq = 0, dirDReq = 0, dirDWe = 0;
    logic [31:0] dirIfAddr = 0, dirDAddr = 0, dirDWdata = 0;
    int unsigned ifPct = 0, dPct = 0;
    int          slaveDelay = -1;
    bit          spurious = 0;

    assign IF_REQ  = runDrivers ? rIfReq  : dirIfReq;
    assign IF_ADDR = runDrivers ? rIfAddr : dirIfAddr;
    assign D_REQ   = runDrivers ? rDReq   : dirDReq;
    assign D_WE    = runDrivers ? rDWe    : dirDWe;
    assign D_ADDR  = runDrivers ? rDAddr  : dirDAddr;
    assign D_WDATA = runDrivers ? rDWdata : dirDWdata;
    assign D_SIZE  = runDrivers ? rDSize  : 2'd2;
    assign D_SIGN  = runDrivers ? rDSign  : 1'b0;

    // reference model state
    int          checks = 0;
    int          failures = 0;
    bit          busy = 0;
    int          starve = 0;
    bit          expIfValid = 0, expDValid = 0;
    bit          modelIfGnt = 0, modelDGnt = 0;
    bit          ifWin, dWin;
    txn_t        mq[$];
    txn_t        t;
    logic [31:0] ifQ[$];
    logic [31:0] dQ[$];
    logic [31:0] refMem[logic [31:0]];
    logic [31:0] slaveMem[logic [31:0]];

    otter_mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_IF_WAIT (MAX_WAIT)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IF_REQ    (IF_REQ),
        .IF_ADDR   (IF_ADDR),
        .IF_GNT    (IF_GNT),
        .IF_VALID  (IF_VALID),
        .IF_RDATA  (IF_RDATA),
        .D_REQ     (D_REQ),
        .D_WE      (D_WE),
        .D_ADDR    (D_ADDR),
        .D_WDATA   (D_WDATA),
        .D_SIZE    (D_SIZE),
        .D_SIGN    (D_SIGN),
        .D_GNT     (D_GNT),
        .D_VALID   (D_VALID),
        .D_RDATA   (D_RDATA),
        .M_REQ     (M_REQ),
        .M_WE      (M_WE),
        .M_ADDR    (M_ADDR),
        .M_WDATA   (M_WDATA),
        .M_SIZE    (M_SIZE),
        .M_SIGN    (M_SIGN),
        .M_ACK     (M_ACK),
        .M_RDATA   (M_RDATA),
        .STALL_IF  (STALL_IF),
        .STALL_MEM (STALL_MEM)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memDefault(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : memDefault(a);
    endfunction

    function automatic logic [31:0] slaveRead(input logic [31:0] a);
        return slaveMem.exists(a) ? slaveMem[a] : memDefault(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard/monitor: predicts grants from the arbitration rules, compares
    // every cycle, and pops expected results whenever a VALID appears
    always @(negedge CLK) begin
        if (!RESET_N) begin
            checkOutput("reset M_REQ", 32'(M_REQ), 32'd0);
            checkOutput("reset IF_GNT", 32'(IF_GNT), 32'd0);
            checkOutput("reset D_GNT", 32'(D_GNT), 32'd0);
            checkOutput("reset IF_VALID", 32'(IF_VALID), 32'd0);
            checkOutput("reset D_VALID", 32'(D_VALID), 32'd0);
            busy = 0; starve = 0; expIfValid = 0; expDValid = 0;
            modelIfGnt = 0; modelDGnt = 0;
            mq.delete(); ifQ.delete(); dQ.delete();
        end else begin
            dWin  = !busy && D_REQ && !(IF_REQ && starve == MAX_WAIT);
            ifWin = !busy && IF_REQ && !dWin;
            checkOutput("IF_GNT", 32'(IF_GNT), 32'(ifWin));
            checkOutput("D_GNT", 32'(D_GNT), 32'(dWin));
            checkOutput("M_REQ", 32'(M_REQ), 32'(busy));
            checkOutput("IF_VALID timing", 32'(IF_VALID), 32'(expIfValid));
            checkOutput("D_VALID timing", 32'(D_VALID), 32'(expDValid));
            checkOutput("STALL_IF", 32'(STALL_IF), 32'(IF_REQ && !expIfValid));
            checkOutput("STALL_MEM", 32'(STALL_MEM), 32'(D_REQ && !expDValid));
            if (busy && mq.size() > 0) begin
                t = mq[0];
                checkOutput("M_ADDR", M_ADDR, t.addr);
                checkOutput("M_WE", 32'(M_WE), 32'(t.we));
                if (t.isD) begin
                    checkOutput("M_WDATA", M_WDATA, t.wdata);
                    checkOutput("M_SIZE", 32'(M_SIZE), 32'(t.size));
                    checkOutput("M_SIGN", 32'(M_SIGN), 32'(t.sign));
                end
            end
            if (IF_VALID) begin
                if (ifQ.size() == 0) checkOutput("IF_VALID unexpected", 32'(IF_VALID), 32'd0);
                else                 checkOutput("IF_RDATA", IF_RDATA, ifQ.pop_front());
            end
            if (D_VALID) begin
                if (dQ.size() == 0) checkOutput("D_VALID unexpected", 32'(D_VALID), 32'd0);
                else                checkOutput("D_RDATA", D_RDATA, dQ.pop_front());
            end
            expIfValid = 0;
            expDValid  = 0;
            if (busy && M_ACK) begin
                t = mq.pop_front();
                if (t.isD) begin
                    if (t.we) begin
                        refMem[t.addr] = t.wdata;
                        dQ.push_back(32'd0);
                    end else begin
                        dQ.push_back(refRead(t.addr));
                    end
                    expDValid = 1;
                end else begin
                    ifQ.push_back(refRead(t.addr));
                    expIfValid = 1;
                end
                busy = 0;
            end
            if (dWin) begin
                t = '{isD: 1, we: D_WE, addr: D_ADDR, wdata: D_WDATA, size: D_SIZE, sign: D_SIGN};
                mq.push_back(t);
                busy = 1;
                if (IF_REQ && starve < MAX_WAIT) starve++;
            end else if (ifWin) begin
                t = '{isD: 0, we: 0, addr: IF_ADDR, wdata: 32'd0, size: 2'd2, sign: 0};
                mq.push_back(t);
                busy = 1;
                starve = 0;
            end
            modelIfGnt = ifWin;
            modelDGnt  = dWin;
        end
    end

    // Random fetch requester: holds each request until the model grants it
    initial begin
        forever begin
            @(posedge CLK); #1;
            if (runDrivers && RESET_N && (!rIfReq || modelIfGnt)) begin
                if ($urandom_range(99) < ifPct) begin
                    rIfReq  = 1'b1;
                    rIfAddr = 32'h100 + ($urandom_range(63) << 2);
                end else begin
                    rIfReq = 1'b0;
                end
            end
        end
    end

    // Random data requester: mixes loads and stores over the fetch address range
    initial begin
        forever begin
            @(posedge CLK); #1;
            if (runDrivers && RESET_N && (!rDReq || modelDGnt)) begin
                if ($urandom_range(99) < dPct) begin
                    rDReq   = 1'b1;
                    rDWe    = 1'($urandom_range(1));
                    rDAddr  = 32'h100 + ($urandom_range(63) << 2);
                    rDWdata = $urandom;
                    rDSize  = 2'($urandom_range(2));
                    rDSign  = 1'($urandom_range(1));
                end else begin
                    rDReq = 1'b0;
                end
            end
        end
    end

    // Memory responder: acks after a delay, stores writes, and sometimes
    // pulses a stray M_ACK while the bus is idle
    initial begin
        bit inTxn;
        int cnt;
        inTxn = 0; cnt = 0;
        M_ACK = 1'b0; M_RDATA = 32'd0;
        forever begin
            @(posedge CLK); #1;
            M_ACK = 1'b0;
            if (!RESET_N) begin
                inTxn = 0;
            end else if (M_REQ) begin
                if (!inTxn) begin
                    inTxn = 1;
                    cnt = (slaveDelay >= 0) ? slaveDelay : int'($urandom_range(3));
                end
                if (cnt == 0) begin
                    M_ACK = 1'b1;
                    inTxn = 0;
                    if (M_WE) begin
                        slaveMem[M_ADDR] = M_WDATA;
                        M_RDATA = $urandom;
                    end else begin
                        M_RDATA = slaveRead(M_ADDR);
                    end
                end else begin
                    cnt--;
                end
            end else begin
                inTxn = 0;
                M_RDATA = $urandom;
                if (spurious && $urandom_range(7) == 0) M_ACK = 1'b1;
            end
        end
    end

    // Directed request: raise the chosen ports, drop each once the model grants it
    task automatic applyStimulus(input bit wantIf, input logic [31:0] ifAddr,
                                 input bit wantD, input bit we,
                                 input logic [31:0] dAddr, input logic [31:0] wdata);
        bit pendIf, pendD;
        @(posedge CLK); #2;
        pendIf = wantIf; pendD = wantD;
        if (wantIf) begin dirIfReq = 1; dirIfAddr = ifAddr; end
        if (wantD)  begin dirDReq = 1; dirDWe = we; dirDAddr = dAddr; dirDWdata = wdata; end
        for (int c = 0; c < 100 && (pendIf || pendD); c++) begin
            @(posedge CLK); #2;
            if (pendIf && modelIfGnt) begin dirIfReq = 0; pendIf = 0; end
            if (pendD && modelDGnt)   begin dirDReq = 0; pendD = 0; end
        end
        checkOutput("grant timeout", {30'd0, pendIf, pendD}, 32'd0);
        dirIfReq = 0; dirDReq = 0;
    endtask

    task automatic waitIdle();
        for (int c = 0; c < 200 && (busy || expIfValid || expDValid); c++) @(posedge CLK);
        checkOutput("idle timeout", 32'(busy), 32'd0);
        @(posedge CLK);
    endtask

    initial begin
        RESET_N = 1'b1;
        #1 RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK); #2 RESET_N = 1'b1;

        // single fetch with immediate ack
        refMem[32'h100] = 32'h0000_0013;
        slaveMem[32'h100] = 32'h0000_0013;
        slaveDelay = 0;
        applyStimulus(1, 32'h100, 0, 0, 32'h0, 32'h0);
        waitIdle();

        // data load and fetch collide: data first, fetch after
        slaveDelay = -1;
        applyStimulus(1, 32'h104, 1, 0, 32'h2000, 32'h0);
        waitIdle();

        // slow store to the IO region
        slaveDelay = 5;
        applyStimulus(0, 32'h0, 1, 1, 32'h1100_0000, 32'hDEAD_BEEF);
        waitIdle();

        // reset while the data transaction is outstanding
        slaveDelay = 1000;
        applyStimulus(0, 32'h0, 1, 1, 32'h2000, 32'h1234_5678);
        repeat (3) @(posedge CLK);
        @(negedge CLK); #2;
        checkOutput("M_REQ before reset", 32'(M_REQ), 32'd1);
        RESET_N = 1'b0;
        #1;
        checkOutput("M_REQ async drop", 32'(M_REQ), 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK); #2 RESET_N = 1'b1;
        slaveDelay = -1;

        // stray acks while idle
        spurious = 1;
        repeat (20) @(posedge CLK);

        // both ports saturated: starvation limit governs the interleave
        @(posedge CLK); #2;
        ifPct = 100; dPct = 100; runDrivers = 1;
        repeat (300) @(posedge CLK);

        // mixed random traffic
        #2 ifPct = 50; dPct = 50;
        repeat (1500) @(posedge CLK);

        #2 runDrivers = 0;
        waitIdle();
        repeat (3) @(posedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
